// File: rtl/alsu_operand_issue_stage.sv
// rtl/alsu_operand_issue_stage.sv - registered operand issue stage feeding the ALSU functional-unit groups
// Buffers legal {a, b, group, sel} requests in a small FIFO; illegal opcodes are consumed and counted.
module alsu_operand_issue_stage #(
    parameter int W     = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [5:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [3:0]       out_group,
    output logic [1:0]       out_sel,
    output logic             err_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_a   [DEPTH];
    logic [W-1:0]  mem_b   [DEPTH];
    logic [3:0]    mem_grp [DEPTH];
    logic [1:0]    mem_sel [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic illegal;
    logic accept;
    logic push;
    logic pop;

    // in_ready depends only on registered occupancy, so a pop never frees a slot in the same cycle
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign illegal   = (in_op >= 6'd40);
    assign accept    = in_valid & in_ready;
    assign push      = accept & ~illegal;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_grp[wr_ptr] <= in_op[5:2];
            mem_sel[wr_ptr] <= in_op[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            err_illegal <= accept & illegal;
            if (accept && illegal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

    // Idle outputs are held at zero so downstream groups never see stale operands
    assign out_a     = out_valid ? mem_a[rd_ptr]   : '0;
    assign out_b     = out_valid ? mem_b[rd_ptr]   : '0;
    assign out_group = out_valid ? mem_grp[rd_ptr] : '0;
    assign out_sel   = out_valid ? mem_sel[rd_ptr] : '0;

endmodule

// File: tb/tb_alsu_operand_issue_stage.sv
// tb/tb_alsu_operand_issue_stage.sv - randomized self-checking bench for alsu_operand_issue_stage
// Reference model: a queue of accepted legal requests plus an illegal counter.
module tb_alsu_operand_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [5:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [3:0] out_group;
    logic [1:0] out_sel;
    logic       err_illegal;
    logic [7:0] illegal_cnt;

    alsu_operand_issue_stage #(.W(4), .DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_group(out_group), .out_sel(out_sel),
        .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] op;
    } req_t;

    req_t q[$];
    logic exp_err;
    int   exp_cnt;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [14:0] exp_out();
        int g;
        int s;
        if (q.size() == 0) return '0;
        g = int'(q[0].op) / 4;
        s = int'(q[0].op) % 4;
        return {1'b1, q[0].a, q[0].b, g[3:0], s[1:0]};
    endfunction

    // One clock: drive at negedge, update model at posedge, return at next negedge
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [5:0] op, input logic ordy);
        logic acc;
        logic pp;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        acc = v && (q.size() < 2);
        pp  = ordy && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_err = 1'b0;
            exp_cnt = 0;
        end else begin
            if (pp) void'(q.pop_front());
            exp_err = acc && (op >= 40);
            if (acc && op < 40) q.push_back('{a: a, b: b, op: op});
            if (acc && op >= 40 && exp_cnt < 255) exp_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if ({out_valid, out_a, out_b, out_group, out_sel} !== 15'd0) begin
            bad++; $display("FAIL reset_out got=%h exp=0", {out_valid, out_a, out_b, out_group, out_sel}); end
        total++; if (illegal_cnt !== 8'd0 || err_illegal !== 1'b0) begin
            bad++; $display("FAIL reset_illegal got cnt=%0d err=%b exp 0/0", illegal_cnt, err_illegal); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        step(1, 4'd3, 4'd5, 6'd38, 0);
        total++; if ({out_valid, out_a, out_b, out_group, out_sel} !== {1'b1, 4'd3, 4'd5, 4'd9, 2'd2}) begin
            bad++; $display("FAIL single_out got=%h exp=%h", {out_valid, out_a, out_b, out_group, out_sel},
                            {1'b1, 4'd3, 4'd5, 4'd9, 2'd2}); end
        step(0, 0, 0, 0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_full();
        step(1, 4'd1, 4'd2, 6'd1, 0);
        step(1, 4'd7, 4'd8, 6'd2, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        total++; if ({out_group, out_sel} !== 6'd1) begin bad++; $display("FAIL full_head got=%0d exp=1", {out_group, out_sel}); end
        // push offered while full and popping: must be refused
        step(1, 4'd9, 4'd9, 6'd3, 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%b exp=1", in_ready); end
        total++; if ({out_valid, out_a, out_b, out_group, out_sel} !== {1'b1, 4'd7, 4'd8, 4'd0, 2'd2}) begin
            bad++; $display("FAIL full_second got=%h exp=%h", {out_valid, out_a, out_b, out_group, out_sel},
                            {1'b1, 4'd7, 4'd8, 4'd0, 2'd2}); end
        step(0, 0, 0, 0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        step(1, 4'd2, 4'd2, 6'd45, 0);
        total++; if (out_valid !== 1'b0 || err_illegal !== 1'b1 || illegal_cnt !== 8'd1) begin
            bad++; $display("FAIL illegal_one got v=%b err=%b cnt=%0d exp 0/1/1", out_valid, err_illegal, illegal_cnt); end
        step(0, 0, 0, 0, 0);
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b exp=0", err_illegal); end
        for (int i = 0; i < 300; i++) begin
            step(1, 4'($urandom), 4'($urandom), 6'($urandom_range(63, 40)), 1'($urandom));
            if (err_illegal !== 1'b1) begin
                total++; bad++; $display("FAIL illegal_burst_err i=%0d got=%b exp=1", i, err_illegal);
            end
        end
        total++; if (illegal_cnt !== 8'd255 || exp_cnt != 255) begin
            bad++; $display("FAIL illegal_sat got=%0d exp=255", illegal_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_nowrite got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40; i++) begin
            step(1, 4'($urandom), 4'($urandom), 6'(i), 1);
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_group !== 4'(i / 4) || out_sel !== 2'(i % 4)
                || {out_valid, out_a, out_b, out_group, out_sel} !== exp_out()) begin
                bad++; $display("FAIL stream i=%0d got rdy=%b out=%h exp=%h", i, in_ready,
                                {out_valid, out_a, out_b, out_group, out_sel}, exp_out());
            end
        end
        step(0, 0, 0, 0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            total++;
            if (in_ready !== (q.size() < 2)) begin
                bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, q.size() < 2);
            end
            step(1'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom_range(7) == 0) ? 6'($urandom_range(63, 40)) : 6'($urandom_range(39)),
                 1'($urandom));
            total++;
            if ({out_valid, out_a, out_b, out_group, out_sel} !== exp_out() || err_illegal !== exp_err
                || illegal_cnt !== 8'(exp_cnt)) begin
                bad++; $display("FAIL rand_out i=%0d got=%h err=%b cnt=%0d exp=%h err=%b cnt=%0d", i,
                                {out_valid, out_a, out_b, out_group, out_sel}, err_illegal, illegal_cnt,
                                exp_out(), exp_err, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_inflight();
        step(1, 4'd4, 4'd6, 6'd10, 0);
        step(1, 4'd5, 4'd7, 6'd11, 0);
        rst = 1'b1;
        step(1, 4'd1, 4'd1, 6'd12, 1);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_inflight got v=%b rdy=%b cnt=%0d exp 0/1/0", out_valid, in_ready, illegal_cnt); end
        step(0, 0, 0, 0, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_dropped got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0;
        exp_err = 0; exp_cnt = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_illegal();
        rst = 1'b1; step(0, 0, 0, 0, 0); rst = 1'b0;
        test_stream();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
